// File: rtl/ps2_pkg.sv
// PS/2 keyboard receive path: shared constants and types.
// Scan-code prefixes, decoder states and the buffered event layout.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT  = 8'hE0;
  localparam logic [7:0] PS2_BRK  = 8'hF0;
  localparam logic [7:0] PS2_ERR0 = 8'h00;
  localparam logic [7:0] PS2_ERR1 = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    EXT,
    BRK,
    EXT_BRK
  } dec_state_e;

  typedef struct packed {
    logic       rel;
    logic       ext;
    logic [7:0] code;
  } ps2_event_t;

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: input sync, Key_Clk fall detect, 11-bit shifter,
// start/parity/stop checks and a stall watchdog for partial frames.
module ps2_frame_rx #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_clk,
  input  logic       key_data,
  output logic [7:0] rx_byte,
  output logic       rx_stb,
  output logic       rx_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] kc_sync;
  logic [SYNC_STAGES-1:0] kd_sync;
  logic                   kc_prev;
  logic                   kc_cur;
  logic                   kd_cur;
  logic                   fall;
  logic [3:0]             bit_idx;
  logic [9:0]             shreg;
  logic [TW-1:0]          wd_cnt;
  logic                   frame_ok;

  assign kc_cur   = kc_sync[SYNC_STAGES-1];
  assign kd_cur   = kd_sync[SYNC_STAGES-1];
  assign fall     = kc_prev & ~kc_cur;
  assign frame_ok = ~shreg[0] & (^shreg[9:1]) & kd_cur;

  // Synchronise the idle-high PS/2 lines and remember last Key_Clk level
  always_ff @(posedge clk) begin
    if (rst) begin
      kc_sync <= '1;
      kd_sync <= '1;
      kc_prev <= 1'b1;
    end else begin
      kc_sync <= {kc_sync[SYNC_STAGES-2:0], key_clk};
      kd_sync <= {kd_sync[SYNC_STAGES-2:0], key_data};
      kc_prev <= kc_cur;
    end
  end

  // Shift bits on each fall, check the frame at the stop bit, run watchdog
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_idx <= '0;
      shreg   <= '0;
      wd_cnt  <= '0;
      rx_byte <= '0;
      rx_stb  <= 1'b0;
      rx_err  <= 1'b0;
    end else begin
      rx_stb <= 1'b0;
      rx_err <= 1'b0;
      if (fall) begin
        wd_cnt <= '0;
        if (bit_idx == 4'd10) begin
          bit_idx <= '0;
          if (frame_ok) begin
            rx_stb  <= 1'b1;
            rx_byte <= shreg[8:1];
          end else begin
            rx_err <= 1'b1;
          end
        end else begin
          bit_idx <= bit_idx + 4'd1;
          shreg   <= {kd_cur, shreg[9:1]};
        end
      end else if (bit_idx != 4'd0) begin
        if (wd_cnt == WD_LAST) begin
          bit_idx <= '0;
          wd_cnt  <= '0;
          rx_err  <= 1'b1;
        end else begin
          wd_cnt <= wd_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ps2_scan_controller.sv
// PS/2 scan controller: frame receiver, E0/F0 prefix decoder and a small
// event FIFO feeding the calculator core.
module ps2_scan_controller
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Key_Clk,
  input  logic       Data_in,
  input  logic       Event_ready,
  output logic       Event_valid,
  output logic [7:0] Event_code,
  output logic       Event_ext,
  output logic       Event_release,
  output logic       Frame_error,
  output logic       Overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0] rx_byte;
  logic       rx_stb;
  logic       rx_err;

  dec_state_e st, st_n;
  logic       emit, derr;
  ps2_event_t ev_n, ev_q;
  logic       push_q, derr_q, ovf_q;

  logic       is_bad, is_ext, is_brk;

  ps2_event_t     mem [FIFO_DEPTH];
  logic [AW:0]    wr_ptr, rd_ptr;
  logic [AW-1:0]  rd_idx, last_idx;
  logic           empty, full, pop, do_push;
  ps2_event_t     head;

  ps2_frame_rx #(
    .SYNC_STAGES   (SYNC_STAGES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk     (Clk),
    .rst     (Reset),
    .key_clk (Key_Clk),
    .key_data(Data_in),
    .rx_byte (rx_byte),
    .rx_stb  (rx_stb),
    .rx_err  (rx_err)
  );

  assign is_bad = (rx_byte == PS2_ERR0) || (rx_byte == PS2_ERR1);
  assign is_ext = (rx_byte == PS2_EXT);
  assign is_brk = (rx_byte == PS2_BRK);

  // Decoder state register plus registered emit/error toward the FIFO
  always_ff @(posedge Clk) begin
    if (Reset) begin
      st     <= IDLE;
      push_q <= 1'b0;
      derr_q <= 1'b0;
      ev_q   <= '0;
    end else begin
      st     <= st_n;
      push_q <= emit;
      derr_q <= derr;
      if (emit) ev_q <= ev_n;
    end
  end

  // Prefix decoder: track E0/F0, emit finished key events
  always_comb begin
    st_n = st;
    emit = 1'b0;
    derr = 1'b0;
    ev_n = '{rel: 1'b0, ext: 1'b0, code: rx_byte};
    if (rx_err) begin
      st_n = IDLE;
    end else if (rx_stb) begin
      unique case (1'b1)
        is_bad: begin
          derr = 1'b1;
          st_n = IDLE;
        end
        is_ext: begin
          unique case (st)
            IDLE, EXT: st_n = EXT;
            default: begin
              derr = 1'b1;
              st_n = IDLE;
            end
          endcase
        end
        is_brk: begin
          unique case (st)
            IDLE:    st_n = BRK;
            EXT:     st_n = EXT_BRK;
            default: begin
              derr = 1'b1;
              st_n = IDLE;
            end
          endcase
        end
        default: begin
          emit     = 1'b1;
          st_n     = IDLE;
          ev_n.ext = (st == EXT) || (st == EXT_BRK);
          ev_n.rel = (st == BRK) || (st == EXT_BRK);
        end
      endcase
    end
  end

  assign rd_idx   = rd_ptr[AW-1:0];
  assign last_idx = rd_idx - 1'b1;
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                    (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop      = ~empty & Event_ready;
  assign do_push  = push_q & (~full | pop);
  // Empty FIFO shows the last popped entry so outputs hold their value
  assign head     = empty ? mem[last_idx] : mem[rd_idx];

  // Event FIFO storage, pointers and overflow pulse
  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf_q  <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      ovf_q <= push_q & full & ~pop;
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= ev_q;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign Event_valid   = ~empty;
  assign Event_code    = head.code;
  assign Event_ext     = head.ext;
  assign Event_release = head.rel;
  assign Frame_error   = rx_err | derr_q;
  assign Overflow      = ovf_q;

endmodule
